lcd_spi_writer: RTL

- Final serialiser of the LCD path. Consumes the 9-bit word and write-enable from the init/show-picture arbiter and drives the 4-wire SPI panel interface (CS, SCLK, MOSI, D/C).
- Word format: bit 8 is D/C (0 = command, 1 = data); bits 7:0 are the payload, sent MSB first in SPI mode 0.
- Holds one word in flight plus one pending word, so upstream can issue back-to-back writes.
- Pulses wr_done once per word so upstream sequencers can advance.

---
 rtl/lcd_spi_writer.sv | 183 ++++++++++++++++++
 1 files changed

// File: rtl/lcd_spi_writer.sv
// Serialises 9-bit {D/C, payload} words onto a 4-wire SPI panel bus (mode 0, MSB first).
// One word in flight plus one pending slot; wr_done pulses once per word as CS is released.
module lcd_spi_writer #(
  parameter int CLK_DIV  = 2,
  parameter int CS_SETUP = 1,
  parameter int CS_HOLD  = 1
) (
  input  logic       sys_clk_50MHz,
  input  logic       sys_rst_n,
  input  logic [8:0] data,
  input  logic       en_write,
  output logic       wr_done,
  output logic       busy,
  output logic       overflow,
  output logic       lcd_cs,
  output logic       lcd_sclk,
  output logic       lcd_mosi,
  output logic       lcd_dc
);

  localparam int MAX_AB = (CLK_DIV > CS_SETUP) ? CLK_DIV : CS_SETUP;
  localparam int MAXC   = (MAX_AB > CS_HOLD) ? MAX_AB : CS_HOLD;
  localparam int CNT_W  = $clog2(MAXC + 1);

  localparam logic [CNT_W-1:0] DIV_LD   = CNT_W'(CLK_DIV - 1);
  localparam logic [CNT_W-1:0] SETUP_LD = CNT_W'(CS_SETUP - 1);
  localparam logic [CNT_W-1:0] HOLD_LD  = CNT_W'(CS_HOLD - 1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SETUP = 3'd1,
    SHIFT = 3'd2,
    HOLD  = 3'd3,
    DONE  = 3'd4
  } state_t;

  state_t           state, state_nxt;
  logic             en_write_d;
  logic [7:0]       sh, sh_nxt;
  logic             dc, dc_nxt;
  logic             sclk, sclk_nxt;
  logic [2:0]       bit_cnt, bit_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [8:0]       pend, pend_nxt;
  logic             pend_vld, pend_vld_nxt;
  logic             ovf, ovf_nxt;

  logic             req;
  logic             launch;
  logic             launch_pend;
  logic [8:0]       launch_word;
  logic             req_direct;

  assign req = en_write & ~en_write_d;

  always_ff @(posedge sys_clk_50MHz or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state      <= IDLE;
      en_write_d <= 1'b0;
      sh         <= '0;
      dc         <= 1'b0;
      sclk       <= 1'b0;
      bit_cnt    <= '0;
      cnt        <= '0;
      pend       <= '0;
      pend_vld   <= 1'b0;
      ovf        <= 1'b0;
    end else begin
      state      <= state_nxt;
      en_write_d <= en_write;
      sh         <= sh_nxt;
      dc         <= dc_nxt;
      sclk       <= sclk_nxt;
      bit_cnt    <= bit_nxt;
      cnt        <= cnt_nxt;
      pend       <= pend_nxt;
      pend_vld   <= pend_vld_nxt;
      ovf        <= ovf_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    sh_nxt       = sh;
    dc_nxt       = dc;
    sclk_nxt     = sclk;
    bit_nxt      = bit_cnt;
    cnt_nxt      = cnt;
    pend_nxt     = pend;
    pend_vld_nxt = pend_vld;
    ovf_nxt      = ovf;
    launch       = 1'b0;
    launch_pend  = 1'b0;
    launch_word  = data;
    req_direct   = 1'b0;

    unique case (state)
      IDLE: begin
        // A word parked while DONE was exiting takes priority over a new request.
        if (pend_vld) begin
          launch      = 1'b1;
          launch_pend = 1'b1;
          launch_word = pend;
        end else if (req) begin
          launch      = 1'b1;
          req_direct  = 1'b1;
          launch_word = data;
        end
      end
      SETUP: begin
        if (cnt == '0) begin
          state_nxt = SHIFT;
          cnt_nxt   = DIV_LD;
          bit_nxt   = '0;
          sclk_nxt  = 1'b0;
        end else begin
          cnt_nxt = cnt - 1'b1;
        end
      end
      SHIFT: begin
        if (cnt != '0) begin
          cnt_nxt = cnt - 1'b1;
        end else if (!sclk) begin
          sclk_nxt = 1'b1;
          cnt_nxt  = DIV_LD;
        end else if (bit_cnt == 3'd7) begin
          state_nxt = HOLD;
          sclk_nxt  = 1'b0;
          cnt_nxt   = HOLD_LD;
        end else begin
          // Next bit appears on MOSI together with the falling SCLK edge.
          sclk_nxt = 1'b0;
          sh_nxt   = {sh[6:0], 1'b0};
          bit_nxt  = bit_cnt + 1'b1;
          cnt_nxt  = DIV_LD;
        end
      end
      HOLD: begin
        if (cnt == '0) state_nxt = DONE;
        else           cnt_nxt   = cnt - 1'b1;
      end
      DONE: begin
        if (pend_vld) begin
          launch      = 1'b1;
          launch_pend = 1'b1;
          launch_word = pend;
        end else begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase

    if (launch) begin
      state_nxt = SETUP;
      sh_nxt    = launch_word[7:0];
      dc_nxt    = launch_word[8];
      sclk_nxt  = 1'b0;
      cnt_nxt   = SETUP_LD;
    end

    if (launch_pend) pend_vld_nxt = 1'b0;

    // Requests not launched directly go to the pending slot, freed this cycle if consumed.
    if (req && !req_direct) begin
      if (!pend_vld || launch_pend) begin
        pend_nxt     = data;
        pend_vld_nxt = 1'b1;
      end else begin
        ovf_nxt = 1'b1;
      end
    end
  end

  assign lcd_cs   = (state == IDLE) || (state == DONE);
  assign lcd_sclk = sclk;
  assign lcd_mosi = sh[7];
  assign lcd_dc   = dc;
  assign wr_done  = (state == DONE);
  assign busy     = (state != IDLE) || pend_vld;
  assign overflow = ovf;

endmodule
